// File: rtl/sprite_row_sequencer_if.sv
// Beam, sprite-ROM and pixel-out bundle for sprite_row_sequencer.
// slave: the sequencer side; master: timing gen / ROM / colour mux side.
// Signals: pixel_tick, video_on, hcount, vcount, sprite_x, sprite_y,
//   rom_row, rom_rgb, pix_rgb, pix_valid, busy.
interface sprite_row_sequencer_if #(
   parameter int SPR_W = 40
);
   logic                  pixel_tick;
   logic                  video_on;
   logic [9:0]            hcount;
   logic [9:0]            vcount;
   logic [9:0]            sprite_x;
   logic [9:0]            sprite_y;
   logic [4:0]            rom_row;
   logic [SPR_W*12-1:0]   rom_rgb;
   logic [11:0]           pix_rgb;
   logic                  pix_valid;
   logic                  busy;

   modport slave (
      input  pixel_tick, video_on, hcount, vcount,
      input  sprite_x, sprite_y, rom_rgb,
      output rom_row, pix_rgb, pix_valid, busy
   );

   modport master (
      output pixel_tick, video_on, hcount, vcount,
      output sprite_x, sprite_y, rom_rgb,
      input  rom_row, pix_rgb, pix_valid, busy
   );
endinterface

// File: rtl/sprite_row_sequencer.sv
// Streams one sprite ROM row per scan line into the VGA pixel path.
// Ports: clk, rst_n (async active-low), bus (sprite_row_sequencer_if.slave).
// Option: define SPRITE_TRANSPARENCY_EN to turn 12'hFFF pixels transparent.
module sprite_row_sequencer #(
   parameter int SPR_W = 40,
   parameter int SPR_H = 30
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sprite_row_sequencer_if.slave  bus
);
   localparam int RW = SPR_W * 12;
   localparam int CW = $clog2(SPR_W);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHIFT
   } state_e;

   state_e          state_q, state_d;
   logic [4:0]      rom_row_q, rom_row_d;
   logic [11:0]     pix_rgb_q, pix_rgb_d;
   logic            pix_valid_q, pix_valid_d;
   logic [RW-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]   col_q, col_d;

   logic [9:0]      dy;
   logic [9:0]      trig_col;
   logic            v_hit;
   logic            trig;
   logic [11:0]     pix;

   // Modulo-1024 arithmetic: sprite_x = 0 maps to 1023 and never fires.
   assign dy       = bus.vcount - bus.sprite_y;
   assign trig_col = bus.sprite_x - 10'd1;
   assign v_hit    = dy < 10'(SPR_H);
   assign trig     = v_hit && (bus.hcount == trig_col);
   assign pix      = shreg_q[RW-1 -: 12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rom_row_q   <= '0;
         pix_rgb_q   <= '0;
         pix_valid_q <= 1'b0;
         shreg_q     <= '0;
         col_q       <= '0;
      end else begin
         state_q     <= state_d;
         rom_row_q   <= rom_row_d;
         pix_rgb_q   <= pix_rgb_d;
         pix_valid_q <= pix_valid_d;
         shreg_q     <= shreg_d;
         col_q       <= col_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rom_row_d   = rom_row_q;
      pix_rgb_d   = pix_rgb_q;
      pix_valid_d = pix_valid_q;
      shreg_d     = shreg_q;
      col_d       = col_q;

      if (bus.pixel_tick && !bus.video_on) begin
         // Leaving the visible area clips the row; rom_row is kept.
         state_d     = IDLE;
         pix_valid_d = 1'b0;
         pix_rgb_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.pixel_tick) begin
                  pix_valid_d = 1'b0;
                  pix_rgb_d   = '0;
                  if (trig) begin
                     rom_row_d = dy[4:0];
                     col_d     = '0;
                     state_d   = FETCH;
                  end
               end
            end
            FETCH: begin
               // ROM data for the new row address is valid one clock on.
               shreg_d = bus.rom_rgb;
               state_d = SHIFT;
               if (bus.pixel_tick) begin
                  pix_valid_d = 1'b0;
                  pix_rgb_d   = '0;
               end
            end
            SHIFT: begin
               if (bus.pixel_tick) begin
`ifdef SPRITE_TRANSPARENCY_EN
                  pix_valid_d = (pix != 12'hFFF);
                  pix_rgb_d   = (pix == 12'hFFF) ? 12'h000 : pix;
`else
                  pix_valid_d = 1'b1;
                  pix_rgb_d   = pix;
`endif
                  shreg_d = shreg_q << 12;
                  col_d   = col_q + CW'(1);
                  if (col_q == CW'(SPR_W - 1)) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.rom_row   = rom_row_q;
   assign bus.pix_rgb   = pix_rgb_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sprite_row_sequencer.sv
// Scoreboard bench for sprite_row_sequencer: directed scan lines.
// Driver queues expected pixels per tick; monitor pops and compares.
module tb_sprite_row_sequencer;
   localparam int SPR_W = 40;
   localparam int SPR_H = 30;
   localparam int NONE  = 1023;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sprite_row_sequencer_if #(.SPR_W(SPR_W)) bus ();

   sprite_row_sequencer #(
      .SPR_W(SPR_W),
      .SPR_H(SPR_H)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          h;
      logic        v;
      logic [11:0] rgb;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [4:0] exp_row;

   // ROM contents: 8 white pixels, one blue, then a row/col pattern.
   function automatic logic [11:0] rom_pix(input logic [4:0] r, input int c);
      if (c < 8) return 12'hFFF;
      if (c == 8) return 12'h00F;
      return {1'b0, r, 6'(c)};
   endfunction

   function automatic logic [SPR_W*12-1:0] rom_word(input logic [4:0] r);
      logic [SPR_W*12-1:0] w;
      w = '0;
      for (int c = 0; c < SPR_W; c++) begin
         w[SPR_W*12-1-12*c -: 12] = rom_pix(r, c);
      end
      return w;
   endfunction

   assign bus.rom_rgb = rom_word(bus.rom_row);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      if (bus.pixel_tick === 1'b1) begin
         #1;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got output with no expected entry");
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("pix_valid h=%0d", e.h), 32'(bus.pix_valid), 32'(e.v));
            chk($sformatf("pix_rgb h=%0d", e.h), 32'(bus.pix_rgb), 32'(e.rgb));
         end
      end
   end

   task automatic run_line(input logic [9:0] vc, input logic [9:0] sx,
                           input logic [9:0] sy, input int last_h,
                           input int von_end, input int rst_h);
      logic [9:0]  dy;
      bit          trig;
      int          x;
      exp_t        e;
      logic [11:0] p;
      dy   = vc - sy;
      x    = int'(sx);
      trig = (dy < 10'(SPR_H)) && (x != 0) && (x - 1 <= last_h) &&
             (x - 1 < von_end);
      bus.vcount   = vc;
      bus.sprite_x = sx;
      bus.sprite_y = sy;
      for (int h = 0; h <= last_h; h++) begin
         bit von;
         bit on;
         bit bexp;
         von  = (h < von_end);
         on   = trig && h >= x && h < x + SPR_W && von && h <= rst_h;
         bexp = trig && h >= x - 1 && h <= x + SPR_W - 2 && von && h <= rst_h;
         e.h   = h;
         e.v   = 1'b0;
         e.rgb = 12'h000;
         if (on) begin
            p = rom_pix(dy[4:0], h - x);
`ifdef SPRITE_TRANSPARENCY_EN
            if (p != 12'hFFF) begin
               e.v   = 1'b1;
               e.rgb = p;
            end
`else
            e.v   = 1'b1;
            e.rgb = p;
`endif
         end
         bus.hcount   = 10'(h);
         bus.video_on = von;
         @(negedge clk);
         sb_q.push_back(e);
         bus.pixel_tick = 1'b1;
         @(negedge clk);
         bus.pixel_tick = 1'b0;
         @(negedge clk);
         if (trig && h == x - 1) begin
            exp_row = dy[4:0];
            chk($sformatf("rom_row trig vc=%0d", vc), 32'(bus.rom_row), 32'(exp_row));
         end
         chk($sformatf("busy h=%0d", h), 32'(bus.busy), 32'(bexp));
         if (h == rst_h) begin
            rst_n = 1'b0;
            #1;
            chk("rst pix_valid", 32'(bus.pix_valid), 32'(0));
            chk("rst busy", 32'(bus.busy), 32'(0));
            chk("rst pix_rgb", 32'(bus.pix_rgb), 32'(0));
            exp_row = 5'd0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         @(negedge clk);
      end
      chk($sformatf("rom_row eol vc=%0d", vc), 32'(bus.rom_row), 32'(exp_row));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.pixel_tick = 1'b0;
      bus.video_on   = 1'b0;
      bus.hcount     = '0;
      bus.vcount     = '0;
      bus.sprite_x   = '0;
      bus.sprite_y   = '0;
      exp_row        = 5'd0;
      repeat (3) @(negedge clk);
      chk("reset rom_row", 32'(bus.rom_row), 32'(0));
      chk("reset pix_rgb", 32'(bus.pix_rgb), 32'(0));
      chk("reset pix_valid", 32'(bus.pix_valid), 32'(0));
      chk("reset busy", 32'(bus.busy), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_line(10'd10, 10'd100, 10'd50, 799, NONE, NONE);
      run_line(10'd52, 10'd100, 10'd50, 199, NONE, NONE);
      run_line(10'd49, 10'd100, 10'd50, 199, NONE, NONE);
      run_line(10'd80, 10'd100, 10'd50, 199, NONE, NONE);
      run_line(10'd79, 10'd100, 10'd50, 199, NONE, NONE);
      run_line(10'd52, 10'd0,   10'd50, 199, NONE, NONE);
      run_line(10'd60, 10'd780, 10'd50, 810, 800,  NONE);
      chk("abort busy", 32'(bus.busy), 32'(0));
      run_line(10'd52, 10'd100, 10'd50, 199, NONE, 120);
      run_line(10'd53, 10'd100, 10'd50, 199, NONE, NONE);

      repeat (8) @(negedge clk);
      chk("sb drained", 32'(sb_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_row_sequencer.md
# sprite_row_sequencer

Sequences the 30-row × 40-pixel sprite ROM (12-bit RGB per pixel, 480-bit row word) into the VGA pixel stream. Per scan line it detects when the beam reaches the sprite, drives the ROM row address, captures the row word into a shift register, and emits one 12-bit pixel per pixel tick with a valid flag. It sits between the VGA timing generator and the colour mux that overlays the sprite on the calculator display.

## Interface

- SPR_W, 40: sprite width in pixels; the ROM word width is SPR_W*12.
- SPR_H, 30: sprite height in rows.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_tick  in  1  one-clock pixel enable; never asserted on two consecutive clocks.
- video_on  in  1  high inside the visible area.
- hcount  in  10  current beam column.
- vcount  in  10  current beam row.
- sprite_x  in  10  left column of the sprite.
- sprite_y  in  10  top row of the sprite.
- rom_row  out  5  row address to the sprite ROM; registered.
- rom_rgb  in  480  combinational ROM data for rom_row.
- pix_rgb  out  12  sprite pixel colour; registered.
- pix_valid  out  1  pix_rgb is an opaque sprite pixel for the current beam position.
- busy  out  1  high in FETCH and SHIFT.

## Operation

- States: IDLE, FETCH, SHIFT. Reset state is IDLE.
- Vertical hit: (vcount - sprite_y) mod 1024 < SPR_H, computed in 10-bit unsigned arithmetic.
- IDLE transition: on a pixel_tick with video_on=1, a vertical hit, and hcount == (sprite_x - 1) mod 1024:
  - rom_row <= (vcount - sprite_y)[4:0]
  - col <= 0
  - next state FETCH
- Consequence of the modulo compare: sprite_x = 0 compares against 1023, which never occurs, so the sprite is not drawn.
- FETCH: on the next clock, unconditionally:
  - shreg <= rom_rgb
  - next state SHIFT
- SHIFT: on each pixel_tick:
  - pix_rgb <= shreg[479:468] (leftmost pixel first)
  - shreg <= shreg << 12
  - col <= col + 1
  - when col == SPR_W-1, return to IDLE after this emission
- pix_valid is 1 for an emitted pixel, subject to Configuration.
- On a pixel_tick in IDLE or FETCH: pix_rgb <= 0 and pix_valid <= 0.
- Abort: video_on=0 on any pixel_tick forces IDLE, pix_valid <= 0 and pix_rgb <= 0. rom_row holds its value.
- sprite_x, sprite_y and vcount are used only at the IDLE trigger. Changes mid-line take effect on the next line.
- Right-edge clipping is done by video_on abort only. No wrap to the next line.
- busy = (state != IDLE).

## Timing

- Reset values: rom_row=0, pix_rgb=0, pix_valid=0, busy=0, shreg=0, col=0.
- Trigger tick at hcount = sprite_x-1. The ROM is sampled one clock later, which is always before the next tick.
- The outputs registered on the tick where hcount = sprite_x+k carry column k, for k = 0..SPR_W-1.
- Each emitted pixel holds for one full tick period.
- The tick at hcount = sprite_x+SPR_W clears pix_valid.
- FETCH always takes exactly one clock and ignores pixel_tick. This requires at least two clocks per tick, which the tick definition guarantees.
- Reset asserted mid-line: all outputs clear immediately. After release the block waits for the next trigger; no partial line is emitted.

## Configuration

- SPRITE_TRANSPARENCY_EN defined: an emitted pixel equal to 12'hFFF gives pix_valid=0 and pix_rgb=0, so the white background shows through. All other pixels behave as in Operation.
- Not defined: every emitted pixel in SHIFT gives pix_valid=1 with the raw ROM colour, including 12'hFFF.

## Test plan

- Reset then idle scan: sprite_x=100, sprite_y=50, vcount=10, full line of ticks -> rom_row=0, pix_valid never 1, busy never 1.
- Basic draw, macro undefined: vcount=52, sprite_x=100, ROM model returns row 2 -> rom_row=2 after the tick at hcount=99; pixels at hcount 100..139 equal the 40 ROM nibble-triples MSB-first (hcount 108 gives 12'h00F); pix_valid=1 for exactly 40 ticks.
- Transparency, macro defined, same stimulus -> pix_valid=0 at hcount 100..107 (12'hFFF pixels); pix_valid=1 with 12'h00F at hcount 108.
- Vertical bounds: vcount=49 and vcount=80 (sprite_y=50) -> no trigger; vcount=79 -> rom_row=29, 40 pixels emitted.
- Abort and clip: sprite_x=780, video_on drops at hcount=800 -> pixels emitted for hcount 780..799 only, then pix_valid=0, state IDLE, busy=0.
- Reset mid-operation: assert rst_n=0 at hcount=120 during SHIFT -> pix_valid=0 and busy=0 asynchronously; after release on the same line, no pixels are emitted until the next qualifying line.
